// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : execute_muldiv
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            One shift-add (multiply) or restoring shift-subtract (divide)
//            step per cycle over XLEN cycles. Divide-by-zero and signed
//            overflow finish in a single cycle. The result is held until the
//            memory stage accepts it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i              clock, all state changes on the rising edge
//   rst                synchronous reset, active-high
//   decode_vaild_i     decode register holds a valid instruction
//   DD_is_muldiv_i     held instruction is an RV32M op
//   DD_muldiv_op_i     funct3 (MUL..REMU)
//   DD_rs1_data_i      operand A
//   DD_rs2_data_i      operand B
//   DD_dstE_i          destination register index
//   flush_i            kill any in-flight op
//   memory_allow_in_i  memory stage accepts a result this cycle
//   execute_allow_in_o unit can accept a new op this cycle
//   E_valid_o          E_result_o / E_dstE_o valid
//   E_result_o         result
//   E_dstE_o           destination register of the result
//   E_busy_o           unit is not idle
// ============================================================================
module execute_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            decode_vaild_i,
  input  logic            DD_is_muldiv_i,
  input  logic [2:0]      DD_muldiv_op_i,
  input  logic [XLEN-1:0] DD_rs1_data_i,
  input  logic [XLEN-1:0] DD_rs2_data_i,
  input  logic [4:0]      DD_dstE_i,
  input  logic            flush_i,
  input  logic            memory_allow_in_i,
  output logic            execute_allow_in_o,
  output logic            E_valid_o,
  output logic [XLEN-1:0] E_result_o,
  output logic [4:0]      E_dstE_o,
  output logic            E_busy_o
);

  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        op;
  logic              neg;      // final result must be negated
  logic [XLEN-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   acc_hi;   // product high half / partial remainder
  logic [XLEN-1:0]   acc_lo;   // multiplier->product low half / dividend->quotient

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic start;

  assign execute_allow_in_o = (state == IDLE) | ((state == DONE) & memory_allow_in_i);
  assign E_busy_o           = (state != IDLE);
  assign start              = decode_vaild_i & DD_is_muldiv_i & execute_allow_in_o;

  // --------------------------------------------------------------------------
  // Incoming operand preparation: signedness, magnitudes, special divides
  // --------------------------------------------------------------------------
  logic            in_is_div;
  logic            rs1_signed, rs2_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            in_neg;
  logic            div_by_zero, div_overflow, in_special;
  logic [XLEN-1:0] special_result;

  assign in_is_div = DD_muldiv_op_i[2];
  // DIV/REM (funct3 bit0 clear) treat both operands as signed; MULH and
  // MULHSU treat rs1 as signed, only MULH treats rs2 as signed. MUL's low
  // half is sign-agnostic so it is computed unsigned.
  assign rs1_signed = in_is_div ? ~DD_muldiv_op_i[0]
                                : (DD_muldiv_op_i == 3'd1) | (DD_muldiv_op_i == 3'd2);
  assign rs2_signed = in_is_div ? ~DD_muldiv_op_i[0]
                                : (DD_muldiv_op_i == 3'd1);

  assign sign_a  = rs1_signed & DD_rs1_data_i[XLEN-1];
  assign sign_b  = rs2_signed & DD_rs2_data_i[XLEN-1];
  assign rs1_mag = sign_a ? -DD_rs1_data_i : DD_rs1_data_i;
  assign rs2_mag = sign_b ? -DD_rs2_data_i : DD_rs2_data_i;

  // Remainder takes the dividend's sign; product and quotient take sA^sB.
  assign in_neg = (in_is_div & DD_muldiv_op_i[1]) ? sign_a : (sign_a ^ sign_b);

  assign div_by_zero  = in_is_div & (DD_rs2_data_i == '0);
  assign div_overflow = in_is_div & ~DD_muldiv_op_i[0] &
                        (DD_rs1_data_i == MIN_INT) & (DD_rs2_data_i == ALL_ONES);
  assign in_special   = div_by_zero | div_overflow;

  always_comb begin
    special_result = '0;
    if (div_by_zero)
      special_result = DD_muldiv_op_i[1] ? DD_rs1_data_i : ALL_ONES;
    else if (div_overflow)
      special_result = DD_muldiv_op_i[1] ? '0 : MIN_INT;
  end

  // --------------------------------------------------------------------------
  // One iteration step
  // --------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_fits;
  logic [XLEN-1:0] div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  // Multiply: add multiplicand when the multiplier LSB is set, then shift the
  // whole {hi,lo} pair right; the multiplier drains out of acc_lo as the
  // product's low half shifts in.
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};

  // Divide: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits. The remainder stays below the divisor,
  // so the modular XLEN-bit difference is exact when it fits.
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_fits  = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[XLEN-1:0] - opnd;

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (op[2]) begin
      step_hi = div_fits ? div_diff : div_shift[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], div_fits};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Final sign fix-up and result selection (used on the last step)
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] product, product_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [XLEN-1:0]   calc_result;

  assign product     = {step_hi, step_lo};
  assign product_fix = neg ? -product : product;
  assign quot_fix    = neg ? -step_lo : step_lo;
  assign rem_fix     = neg ? -step_hi : step_hi;

  always_comb begin
    calc_result = '0;
    if (op[2])
      calc_result = op[1] ? rem_fix : quot_fix;
    else if (op == 3'd0)
      calc_result = product_fix[XLEN-1:0];
    else
      calc_result = product_fix[2*XLEN-1:XLEN];
  end

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      op         <= '0;
      neg        <= 1'b0;
      opnd       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      E_valid_o  <= 1'b0;
      E_result_o <= '0;
      E_dstE_o   <= '0;
    end else if (flush_i) begin
      state     <= IDLE;
      counter   <= '0;
      E_valid_o <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          acc_hi  <= step_hi;
          acc_lo  <= step_lo;
          counter <= counter + CNT_W'(1);
          if (counter == LAST_CNT) begin
            counter    <= '0;
            E_result_o <= calc_result;
            E_valid_o  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (memory_allow_in_i) begin
            E_valid_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      // A new op can only start from IDLE or from DONE while retiring, so
      // these assignments take precedence over the ones above.
      if (start) begin
        op       <= DD_muldiv_op_i;
        neg      <= in_neg;
        E_dstE_o <= DD_dstE_i;
        counter  <= '0;
        acc_hi   <= '0;
        acc_lo   <= in_is_div ? rs1_mag : rs2_mag;
        opnd     <= in_is_div ? rs2_mag : rs1_mag;
        if (in_special) begin
          E_result_o <= special_result;
          E_valid_o  <= 1'b1;
          state      <= DONE;
        end else begin
          E_valid_o <= 1'b0;
          state     <= CALC;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_muldiv
// Purpose  : Self-checking bench for execute_muldiv. Directed RV32M vectors,
//            randomized ops against an arithmetic reference model, result
//            hold under backpressure, back-to-back issue, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        decode_vaild_i;
  logic        DD_is_muldiv_i;
  logic [2:0]  DD_muldiv_op_i;
  logic [31:0] DD_rs1_data_i;
  logic [31:0] DD_rs2_data_i;
  logic [4:0]  DD_dstE_i;
  logic        flush_i;
  logic        memory_allow_in_i;
  logic        execute_allow_in_o;
  logic        E_valid_o;
  logic [31:0] E_result_o;
  logic [4:0]  E_dstE_o;
  logic        E_busy_o;

  int checks = 0;
  int errors = 0;

  execute_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i              (clk_i),
    .rst                (rst),
    .decode_vaild_i     (decode_vaild_i),
    .DD_is_muldiv_i     (DD_is_muldiv_i),
    .DD_muldiv_op_i     (DD_muldiv_op_i),
    .DD_rs1_data_i      (DD_rs1_data_i),
    .DD_rs2_data_i      (DD_rs2_data_i),
    .DD_dstE_i          (DD_dstE_i),
    .flush_i            (flush_i),
    .memory_allow_in_i  (memory_allow_in_i),
    .execute_allow_in_o (execute_allow_in_o),
    .E_valid_o          (E_valid_o),
    .E_result_o         (E_result_o),
    .E_dstE_o           (E_dstE_o),
    .E_busy_o           (E_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb, p;
    if (!op[2]) begin
      ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (op == 3'd0) ? p[31:0] : p[63:32];
    end
    case (op)
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ------------------------------------------------------------- helpers
  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
    decode_vaild_i = 1'b1;
    DD_is_muldiv_i = 1'b1;
    DD_muldiv_op_i = op;
    DD_rs1_data_i  = a;
    DD_rs2_data_i  = b;
    DD_dstE_i      = d;
    #1;
    checks++;
    if (execute_allow_in_o !== 1'b1) begin
      errors++;
      $display("FAIL %s allow_at_issue got %b want 1", name, execute_allow_in_o);
    end
    @(posedge clk_i); #1;
    decode_vaild_i = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp,
                             input logic [4:0] d, input int exp_lat);
    int lat = 1;
    int low = 0;
    while (E_valid_o !== 1'b1 && lat < 100) begin
      if (execute_allow_in_o !== 1'b1) low++;
      @(posedge clk_i); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (E_result_o !== exp) begin
      errors++;
      $display("FAIL %s result got %h want %h", name, E_result_o, exp);
    end
    checks++;
    if (E_dstE_o !== d) begin
      errors++;
      $display("FAIL %s dstE got %0d want %0d", name, E_dstE_o, d);
    end
    checks++;
    if (low != exp_lat - 1) begin
      errors++;
      $display("FAIL %s allow_low_cycles got %0d want %0d", name, low, exp_lat - 1);
    end
  endtask

  task automatic retire(input string name);
    memory_allow_in_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (E_valid_o !== 1'b0 || E_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s retire valid=%b busy=%b want 0 0", name, E_valid_o, E_busy_o);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
    drive_op(name, op, a, b, d);
    wait_result(name, ref_result(op, a, b), d, ref_latency(op, a, b));
    retire(name);
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    decode_vaild_i = 0; DD_is_muldiv_i = 0; DD_muldiv_op_i = 0;
    DD_rs1_data_i = 0; DD_rs2_data_i = 0; DD_dstE_i = 0;
    flush_i = 0; memory_allow_in_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst = 1'b0;
    checks++;
    if ({E_valid_o, E_busy_o, E_dstE_o} !== 7'd0 || E_result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs valid=%b busy=%b dst=%0d res=%h want all 0",
               E_valid_o, E_busy_o, E_dstE_o, E_result_o);
    end
    checks++;
    if (execute_allow_in_o !== 1'b1) begin
      errors++;
      $display("FAIL reset allow got %b want 1", execute_allow_in_o);
    end
  endtask

  task automatic test_mul_directed();
    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    checks++;
    if (ref_result(3'd0, 32'd7, 32'hFFFF_FFFD) !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL model_mul got %h want ffffffeb", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD));
    end
    run_op("mulh_ff",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op("mulhu_ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
  endtask

  task automatic test_div_directed();
    run_op("div_-7/2",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op("rem_-7%2",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);
    run_op("divu_7/0",  3'd5, 32'd7, 32'd0, 5'd12);
    run_op("remu_7%0",  3'd7, 32'd7, 32'd0, 5'd13);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op("div_neg_0", 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd16);
    run_op("rem_neg_0", 3'd6, 32'hFFFF_FFF9, 32'd0, 5'd17);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, exp;
    a = $urandom; b = $urandom;
    exp = ref_result(3'd3, a, b);
    memory_allow_in_i = 1'b0;
    drive_op("hold_mulhu", 3'd3, a, b, 5'd21);
    wait_result("hold_mulhu", exp, 5'd21, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (E_valid_o !== 1'b1 || E_result_o !== exp || E_dstE_o !== 5'd21) begin
        errors++;
        $display("FAIL hold_cycle%0d valid=%b res=%h dst=%0d want 1 %h 21",
                 i, E_valid_o, E_result_o, E_dstE_o, exp);
      end
    end
    // Release and issue a new op in the same cycle.
    memory_allow_in_i = 1'b1;
    a = $urandom; b = $urandom_range(1, 1000);
    drive_op("b2b_div", 3'd4, a, b, 5'd22);
    wait_result("b2b_div", ref_result(3'd4, a, b), 5'd22, 33);
    // Second back-to-back issue is a special divide: valid must stay up.
    drive_op("b2b_dbz", 3'd5, a, 32'd0, 5'd23);
    checks++;
    if (E_valid_o !== 1'b1 || E_result_o !== 32'hFFFF_FFFF || E_dstE_o !== 5'd23) begin
      errors++;
      $display("FAIL b2b_dbz valid=%b res=%h dst=%0d want 1 ffffffff 23",
               E_valid_o, E_result_o, E_dstE_o);
    end
    retire("b2b_dbz");
  endtask

  task automatic test_ignore();
    decode_vaild_i = 1'b1;
    DD_is_muldiv_i = 1'b0;
    DD_muldiv_op_i = 3'd0;
    DD_rs1_data_i  = 32'd3;
    DD_rs2_data_i  = 32'd4;
    repeat (3) @(posedge clk_i);
    #1;
    decode_vaild_i = 1'b0;
    checks++;
    if (E_busy_o !== 1'b0 || E_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_non_muldiv busy=%b valid=%b want 0 0", E_busy_o, E_valid_o);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    memory_allow_in_i = 1'b1;
    drive_op("flush_mul", 3'd0, $urandom, $urandom, 5'd7);
    repeat (9) begin @(posedge clk_i); #1; end
    flush_i        = 1'b1;
    decode_vaild_i = 1'b1;
    DD_is_muldiv_i = 1'b1;
    DD_muldiv_op_i = 3'd5;
    DD_rs2_data_i  = 32'd0;
    @(posedge clk_i); #1;
    flush_i        = 1'b0;
    decode_vaild_i = 1'b0;
    checks++;
    if (E_busy_o !== 1'b0 || E_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle busy=%b valid=%b want 0 0", E_busy_o, E_valid_o);
    end
    for (int i = 0; i < 40; i++) begin
      if (E_valid_o !== 1'b0) seen++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_stale_valid got %0d cycles want 0", seen);
    end
    run_op("after_flush", 3'd7, $urandom, 32'd13, 5'd8);
  endtask

  task automatic test_reset_mid();
    run_op("pre_reset", 3'd0, 32'd5, 32'd6, 5'd9);
    drive_op("reset_divu", 3'd5, $urandom, 32'd3, 5'd30);
    repeat (6) begin @(posedge clk_i); #1; end
    rst = 1'b1;
    @(posedge clk_i); #1;
    rst = 1'b0;
    checks++;
    if ({E_valid_o, E_busy_o, E_dstE_o} !== 7'd0 || E_result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid valid=%b busy=%b dst=%0d res=%h want all 0",
               E_valid_o, E_busy_o, E_dstE_o, E_result_o);
    end
    repeat (40) @(posedge clk_i);
    #1;
    checks++;
    if (E_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stale valid got %b want 0", E_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_random();
    test_back_to_back();
    test_ignore();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
